bra_his_tab_par: RTL

Parametrised per-branch history table for the branch predictor front end. It is the successor to the fixed 10-bit, 1024-entry history table and adds:
- configurable history width and depth;
- a registered read port with write-to-read bypass;
- a full-history repair write for misprediction recovery;
- a hardware clear engine that runs automatically after reset and on request.

The index/PC-hash logic feeds it, and its read history drives the pattern-table index generator.

---
 rtl/bra_his_tab_par.sv | 118 +++++++++++
 1 files changed

// File: rtl/bra_his_tab_par.sv
// Per-branch history table: shift updates, repair overwrites, registered read with
// write-first bypass, and a clear engine that zeroes the array after reset or on request.
module bra_his_tab_par #(
    parameter int unsigned HIS_W  = 10,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [HIS_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_taken,
    input  logic              rep_en,
    input  logic [ADDR_W-1:0] rep_addr,
    input  logic [HIS_W-1:0]  rep_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [HIS_W-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              wr_drop_q, wr_drop_d;

    logic [HIS_W-1:0]  mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [HIS_W-1:0]  wdata;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        wr_drop_d = 1'b0;
        unique case (state_q)
            StClear: begin
                we        = 1'b1;
                waddr     = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                wr_drop_d = upd_en | rep_en;
                if (&clr_ptr_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr_req) begin
                    // Writes in the request cycle are discarded; the sweep starts next edge.
                    state_d   = StClear;
                    clr_ptr_d = '0;
                    wr_drop_d = upd_en | rep_en;
                end else if (rep_en) begin
                    we        = 1'b1;
                    waddr     = rep_addr;
                    wdata     = rep_data;
                    wr_drop_d = upd_en;
                end else if (upd_en) begin
                    we    = 1'b1;
                    waddr = upd_addr;
                    wdata = {mem[upd_addr][HIS_W-2:0], upd_taken};
                end
            end
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (state_q == StClear) begin
                rd_data_d = '0;
            end else if (we && (waddr == rd_addr)) begin
                rd_data_d = wdata;
            end else begin
                rd_data_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Storage is deliberately unreset; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_drop  = wr_drop_q;
    assign busy     = (state_q == StClear);

endmodule
